mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning RAM address width (64 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning RAM word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1  input  1  access request from requester 0/1.
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read, for requester 0/1.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  word address for requester 0/1.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W  write data for requester 0/1.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse to requester 0/1.
REQ-010 SHALL have ports rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse to requester 0/1.
REQ-011 SHALL have ports rdata0/rdata1  output  DATA_W  read data for requester 0/1, held until next read completes for that requester.
REQ-012 SHALL have ports Mem_Addr  output  ADDR_W, Mem_Write  output  1, Mem_Read  output  1, Mem_Wdata  output  DATA_W  RAM command bus.
REQ-013 SHALL have port Mem_Rdata  input  DATA_W  RAM read data, valid one clk after the Mem_Read cycle.
REQ-014 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DATA.
REQ-016 IDLE: if any req high, SHALL select a winner, latch its we/addr/wdata, pulse its gnt for that cycle, go to ISSUE; else stay IDLE.
REQ-017 ISSUE: SHALL drive latched Mem_Addr/Mem_Wdata with Mem_Write=we, Mem_Read=~we for exactly one cycle; write -> IDLE, read -> DATA.
REQ-018 DATA: SHALL capture Mem_Rdata into winner's rdata, pulse winner's rvalid for one cycle, go to IDLE.
REQ-019 Mem_Write and Mem_Read SHALL be low in every state except ISSUE and SHALL never be high together.
REQ-020 Latency: gnt to RAM command 1 cycle; gnt to rvalid 2 cycles; write occupies 2 cycles, read 3 cycles.
REQ-021 Requester SHALL hold req/we/addr/wdata stable until gnt; inputs changing after gnt SHALL NOT affect the access in flight.
REQ-022 Requests arriving while busy SHALL be ignored until IDLE; a still-held req SHALL be arbitrated in the next IDLE cycle.
REQ-023 Arbitration: only one req high -> that requester wins; both high -> requester not served last wins (round-robin pointer updated on every gnt).
REQ-024 gnt0 and gnt1 SHALL never be high in the same cycle; rvalid0 and rvalid1 likewise.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, all gnt/rvalid/Mem_Write/Mem_Read/busy low, Mem_Addr/Mem_Wdata/rdata0/rdata1 to 0, last-served pointer to 1 (requester 0 wins first tie).
REQ-026 Reset mid-access SHALL abort it with no rvalid pulse; a write in ISSUE SHALL have Mem_Write dropped immediately.

Configuration
REQ-027 Macro MEM_ARBITER_FIXED_PRIO_EN defined: tie resolved always in favour of requester 0, pointer unused; undefined: round-robin per REQ-023.

Verification
REQ-028 req0 write addr=5 wdata=32'hA5A5_0001 alone -> gnt0 cycle 0, Mem_Write=1 Mem_Addr=5 cycle 1, no rvalid.
REQ-029 After REQ-028, req1 read addr=5 -> gnt1, Mem_Read=1 next cycle, rvalid1=1 with rdata1=32'hA5A5_0001 two cycles after gnt1.
REQ-030 req0 and req1 held high continuously (reads) from reset -> grants alternate 0,1,0,1 every 3 cycles (fixed-prio build: 0,0,0,...).
REQ-031 req1 asserted while busy on req0 access -> gnt1 first IDLE cycle after req0's completion, never earlier.
REQ-032 rst_n pulled low during DATA of a req0 read -> no rvalid0, busy=0 and outputs at reset values asynchronously; first tie afterwards granted to req0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM (IDLE/ISSUE/DATA FSM).
// Define MEM_ARBITER_FIXED_PRIO_EN to resolve ties always toward requester 0 instead of round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Write,
  output logic              Mem_Read,
  output logic [DATA_W-1:0] Mem_Wdata,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                pick1_s;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  // Requester 1 only wins when requester 0 is silent.
  always_comb begin
    pick1_s = ~req0;
  end
`else
  logic last_q, last_d;

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    if (req0 && req1) begin
      pick1_s = ~last_q;
    end else begin
      pick1_s = req1;
    end
  end

  // Pointer follows every grant.
  always_comb begin
    if (gnt0 || gnt1) begin
      last_d = gnt1;
    end else begin
      last_d = last_q;
    end
  end

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Next state, latch of the winning command and all pulse outputs.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    Mem_Write = 1'b0;
    Mem_Read  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0    = ~pick1_s;
          gnt1    = pick1_s;
          win_d   = pick1_s;
          we_d    = pick1_s ? we1 : we0;
          addr_d  = pick1_s ? addr1 : addr0;
          wdata_d = pick1_s ? wdata1 : wdata0;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        Mem_Write = we_q;
        Mem_Read  = ~we_q;
        state_d   = we_q ? IDLE : DATA;
      end
      DATA: begin
        // rdata is passed through during the rvalid cycle and held afterwards.
        if (win_q) begin
          rvalid1  = 1'b1;
          rdata1_d = Mem_Rdata;
        end else begin
          rvalid0  = 1'b1;
          rdata0_d = Mem_Rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      rdata0_q <= {DATA_W{1'b0}};
      rdata1_q <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign rdata0    = rdata0_d;
  assign rdata1    = rdata1_d;
  assign Mem_Addr  = addr_q;
  assign Mem_Wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = 6'd0, addr1 = 6'd0;
  logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [5:0]  Mem_Addr;
  logic        Mem_Write, Mem_Read;
  logic [31:0] Mem_Wdata;
  logic [31:0] Mem_Rdata = 32'd0;
  logic        busy;
  logic [31:0] ram [64];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // RAM: read data valid one cycle after Mem_Read.
  always @(posedge clk) begin
    if (Mem_Write) ram[Mem_Addr] <= Mem_Wdata;
    if (Mem_Read) Mem_Rdata <= ram[Mem_Addr];
  end

  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .Mem_Addr(Mem_Addr), .Mem_Write(Mem_Write), .Mem_Read(Mem_Read),
    .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000) begin errors++; $display("FAIL rst_pulses: got %b want 0000", {gnt0, gnt1, rvalid0, rvalid1}); end
    checks++; if ({Mem_Write, Mem_Read} !== 2'b00) begin errors++; $display("FAIL rst_memcmd: got %b want 00", {Mem_Write, Mem_Read}); end
    checks++; if (Mem_Addr !== 6'd0 || Mem_Wdata !== 32'd0) begin errors++; $display("FAIL rst_membus: got %h/%h want 0/0", Mem_Addr, Mem_Wdata); end
    checks++; if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", rdata0, rdata1); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 32'hA5A5_0001;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b want 10", {gnt0, gnt1}); end
    tick();
    req0 = 1'b0; addr0 = 6'd9; wdata0 = 32'hFFFF_FFFF;
    #1;
    checks++; if ({Mem_Write, Mem_Read} !== 2'b10) begin errors++; $display("FAIL wr_cmd: got %b want 10", {Mem_Write, Mem_Read}); end
    checks++; if (Mem_Addr !== 6'd5 || Mem_Wdata !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_bus: got %h/%h want 05/a5a50001", Mem_Addr, Mem_Wdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
    tick();
    checks++; if ({Mem_Write, rvalid0, rvalid1, busy} !== 4'b0000) begin errors++; $display("FAIL wr_done: got %b want 0000", {Mem_Write, rvalid0, rvalid1, busy}); end
  endtask

  task automatic test_read();
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd5;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL rd_gnt: got %b want 01", {gnt0, gnt1}); end
    tick();
    req1 = 1'b0; addr1 = 6'd0;
    #1;
    checks++; if ({Mem_Write, Mem_Read} !== 2'b01 || Mem_Addr !== 6'd5) begin errors++; $display("FAIL rd_cmd: got %b addr %h want 01 addr 05", {Mem_Write, Mem_Read}, Mem_Addr); end
    tick();
    checks++; if ({rvalid0, rvalid1} !== 2'b01) begin errors++; $display("FAIL rd_rvalid: got %b want 01", {rvalid0, rvalid1}); end
    checks++; if (rdata1 !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_data: got %h want a5a50001", rdata1); end
    tick();
    checks++; if (rvalid1 !== 1'b0 || rdata1 !== 32'hA5A5_0001 || busy !== 1'b0) begin errors++; $display("FAIL rd_hold: got rv %b data %h busy %b want 0 a5a50001 0", rvalid1, rdata1, busy); end
  endtask

  task automatic test_round_robin();
    logic e0, e1;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 6'd1; addr1 = 6'd2;
    for (int k = 0; k < 12; k++) begin
      #1;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      e0 = (k % 3 == 0);
      e1 = 1'b0;
`else
      e0 = (k % 3 == 0) && ((k / 3) % 2 == 0);
      e1 = (k % 3 == 0) && ((k / 3) % 2 == 1);
`endif
      checks++; if ({gnt0, gnt1} !== {e0, e1}) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, {gnt0, gnt1}, {e0, e1}); end
      checks++; if ((Mem_Write && Mem_Read) !== 1'b0) begin errors++; $display("FAIL rr_cmd_excl[%0d]: got %b want not 11", k, {Mem_Write, Mem_Read}); end
      if (k == 11) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL late_gnt0: got %b want 1", gnt0); end
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 6'd20; wdata1 = 32'h0BAD_F00D;
    #1;
    checks++; if (gnt1 !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL late_issue: got gnt1 %b busy %b want 0 1", gnt1, busy); end
    tick();
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL late_data_gnt1: got %b want 0", gnt1); end
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5A5_0001) begin errors++; $display("FAIL late_rd0: got %b %h want 1 a5a50001", rvalid0, rdata0); end
    tick();
    checks++; if (gnt1 !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL late_gnt1: got gnt1 %b busy %b want 1 0", gnt1, busy); end
    tick();
    req1 = 1'b0;
    #1;
    checks++; if (Mem_Write !== 1'b1 || Mem_Addr !== 6'd20 || Mem_Wdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL late_wr1: got %b %h %h want 1 14 0badf00d", Mem_Write, Mem_Addr, Mem_Wdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    tick();
    req0 = 1'b0;
    tick();
    checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL mid_pre: got rvalid0 %b want 1", rvalid0); end
    rst_n = 1'b0;
    #1;
    checks++; if (rvalid0 !== 1'b0 || busy !== 1'b0 || Mem_Read !== 1'b0) begin errors++; $display("FAIL mid_async: got rv %b busy %b rd %b want 000", rvalid0, busy, Mem_Read); end
    checks++; if (Mem_Addr !== 6'd0 || rdata0 !== 32'd0 || rdata1 !== 32'd0) begin errors++; $display("FAIL mid_vals: got %h %h %h want 0 0 0", Mem_Addr, rdata0, rdata1); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL mid_norv: got %b want 0", rvalid0); end
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL mid_tie: got %b want 10", {gnt0, gnt1}); end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_write();
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd33; wdata1 = 32'h1234_5678;
    tick();
    req1 = 1'b0;
    #1;
    checks++; if (Mem_Write !== 1'b1) begin errors++; $display("FAIL wabort_pre: got %b want 1", Mem_Write); end
    rst_n = 1'b0;
    #1;
    checks++; if (Mem_Write !== 1'b0 || Mem_Wdata !== 32'd0) begin errors++; $display("FAIL wabort: got %b %h want 0 0", Mem_Write, Mem_Wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_reset_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
